// File: rtl/input_pkg.sv
// Shared types and constants for the input front end: repeat FSM states,
// PS/2 set-2 scan codes for the game keys, and the default key map.
package input_pkg;

   // Per-channel auto-repeat state
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DAS  = 2'd1,
      ARR  = 2'd2
   } rpt_state_t;

   // PS/2 set-2 scan codes (extended arrows report their second byte)
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_SPACE = 8'h29;

   // Channel indices
   localparam int KEY_LEFT   = 0;
   localparam int KEY_RIGHT  = 1;
   localparam int KEY_DOWN   = 2;
   localparam int KEY_ROTATE = 3;
   localparam int KEY_DROP   = 4;

   localparam int N_KEYS_DEFAULT = 5;

   // Channel i scan code lives at bits [8i+7:8i]
   localparam logic [8*N_KEYS_DEFAULT-1:0] DEFAULT_KEY_MAP =
      {SC_SPACE, SC_UP, SC_DOWN, SC_RIGHT, SC_LEFT};

   // Larger of two integers, used for counter sizing
   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/input_frontend_if.sv
// Keyboard event bus from the PS/2 decoder into the input front end.
interface input_frontend_if;
   logic       kb_valid;
   logic [7:0] kb_code;
   logic       kb_make;

   modport master (output kb_valid, output kb_code, output kb_make);
   modport slave  (input  kb_valid, input  kb_code, input  kb_make);
endinterface

// File: rtl/key_repeat.sv
// One input channel: registers the combined level, detects its rising edge,
// and runs the DAS/ARR auto-repeat FSM that produces command pulses.
module key_repeat
   import input_pkg::*;
#(
   parameter int DAS_TICKS = 10,
   parameter int ARR_TICKS = 3,
   parameter bit REPEAT_EN = 1'b1
) (
   input  logic CLK100MHZ,
   input  logic rst,
   input  logic raw,
   input  logic tick,
   output logic held,
   output logic press,
   output logic cmd
);

   localparam int RW = $clog2(max2(DAS_TICKS, ARR_TICKS) + 1);
   localparam logic [RW-1:0] DAS_LOAD = RW'(DAS_TICKS);
   localparam logic [RW-1:0] ARR_LOAD = RW'(ARR_TICKS);
   localparam logic [RW-1:0] ONE      = RW'(1);
   localparam logic [RW-1:0] ZERO     = {RW{1'b0}};

   logic          held_r;
   logic          press_r;
   logic          cmd_r;
   rpt_state_t    state_r;
   rpt_state_t    state_s;
   logic [RW-1:0] rcnt_r;
   logic [RW-1:0] rcnt_s;
   logic          rpt_s;

   // Level, edge detect, command pulse and FSM state registers
   always_ff @(posedge CLK100MHZ) begin
      if (rst) begin
         held_r  <= 1'b0;
         press_r <= 1'b0;
         cmd_r   <= 1'b0;
         state_r <= IDLE;
         rcnt_r  <= ZERO;
      end else begin
         held_r  <= raw;
         press_r <= raw & ~held_r;
         cmd_r   <= press_r | rpt_s;
         state_r <= state_s;
         rcnt_r  <= rcnt_s;
      end
   end

   // Next state: press reloads the DAS delay even on a tick; release aborts
   always_comb begin
      state_s = state_r;
      rcnt_s  = rcnt_r;
      rpt_s   = 1'b0;
      if (!REPEAT_EN) begin
         state_s = IDLE;
         rcnt_s  = ZERO;
      end else if (press_r) begin
         state_s = DAS;
         rcnt_s  = DAS_LOAD;
      end else begin
         case (state_r)
            IDLE: begin
               state_s = IDLE;
               rcnt_s  = ZERO;
            end
            DAS, ARR: begin
               if (!held_r) begin
                  state_s = IDLE;
                  rcnt_s  = ZERO;
               end else if (tick) begin
                  if (rcnt_r == ONE) begin
                     rpt_s   = 1'b1;
                     rcnt_s  = ARR_LOAD;
                     state_s = ARR;
                  end else begin
                     rcnt_s  = rcnt_r - ONE;
                  end
               end else begin
                  state_s = state_r;
                  rcnt_s  = rcnt_r;
               end
            end
            default: begin
               state_s = IDLE;
               rcnt_s  = ZERO;
            end
         endcase
      end
   end

   assign held  = held_r;
   assign press = press_r;
   assign cmd   = cmd_r;

endmodule

// File: rtl/input_frontend.sv
// Input front end: game-tick generator, button synchroniser/debouncer,
// PS/2 make/break latch via a runtime key map, and per-channel repeat.
module input_frontend
   import input_pkg::*;
#(
   parameter int                N_KEYS      = 5,
   parameter int                TICK_DIV    = 1666667,
   parameter int                DB_CYCLES   = 1000000,
   parameter int                DAS_TICKS   = 10,
   parameter int                ARR_TICKS   = 3,
   parameter logic [N_KEYS-1:0] REPEAT_MASK = 5'b00111
) (
   input  logic                  CLK100MHZ,
   input  logic                  rst,
   input_frontend_if.slave       kb,
   input  logic [8*N_KEYS-1:0]   key_map,
   input  logic [N_KEYS-1:0]     btn_raw,
   output logic                  tick,
   output logic [N_KEYS-1:0]     held,
   output logic [N_KEYS-1:0]     press,
   output logic [N_KEYS-1:0]     cmd
);

   localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DBW = $clog2(DB_CYCLES + 1);
   localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);

   logic [TW-1:0]     tick_cnt_r;
   logic              tick_r;
   logic [N_KEYS-1:0] btn_sync1_r;
   logic [N_KEYS-1:0] btn_sync2_r;
   logic [N_KEYS-1:0] btn_db_r;
   logic [DBW-1:0]    db_cnt_r [N_KEYS];
   logic [N_KEYS-1:0] kb_held_r;
   logic [N_KEYS-1:0] raw_s;

   // Free-running tick divider; tick is high the cycle after the last count
   always_ff @(posedge CLK100MHZ) begin
      if (rst) begin
         tick_cnt_r <= {TW{1'b0}};
         tick_r     <= 1'b0;
      end else if (tick_cnt_r == TICK_LAST) begin
         tick_cnt_r <= {TW{1'b0}};
         tick_r     <= 1'b1;
      end else begin
         tick_cnt_r <= tick_cnt_r + TW'(1);
         tick_r     <= 1'b0;
      end
   end

   // Two-flop synchroniser for the asynchronous buttons
   always_ff @(posedge CLK100MHZ) begin
      if (rst) begin
         btn_sync1_r <= {N_KEYS{1'b0}};
         btn_sync2_r <= {N_KEYS{1'b0}};
      end else begin
         btn_sync1_r <= btn_raw;
         btn_sync2_r <= btn_sync1_r;
      end
   end

   // Debounce: flip only after DB_CYCLES consecutive disagreeing samples
   always_ff @(posedge CLK100MHZ) begin
      if (rst) begin
         btn_db_r <= {N_KEYS{1'b0}};
         for (int i = 0; i < N_KEYS; i++) begin
            db_cnt_r[i] <= {DBW{1'b0}};
         end
      end else begin
         for (int i = 0; i < N_KEYS; i++) begin
            if (btn_sync2_r[i] == btn_db_r[i]) begin
               db_cnt_r[i] <= {DBW{1'b0}};
            end else if (db_cnt_r[i] == DB_LAST) begin
               btn_db_r[i] <= ~btn_db_r[i];
               db_cnt_r[i] <= {DBW{1'b0}};
            end else begin
               db_cnt_r[i] <= db_cnt_r[i] + DBW'(1);
            end
         end
      end
   end

   // Keyboard latch: every channel mapped to the event's code follows make/break
   always_ff @(posedge CLK100MHZ) begin
      if (rst) begin
         kb_held_r <= {N_KEYS{1'b0}};
      end else if (kb.kb_valid) begin
         for (int i = 0; i < N_KEYS; i++) begin
            if (key_map[8*i +: 8] == kb.kb_code) begin
               kb_held_r[i] <= kb.kb_make;
            end
         end
      end else begin
         kb_held_r <= kb_held_r;
      end
   end

   assign raw_s = kb_held_r | btn_db_r;

   for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
      key_repeat #(
         .DAS_TICKS (DAS_TICKS),
         .ARR_TICKS (ARR_TICKS),
         .REPEAT_EN (REPEAT_MASK[g])
      ) u_key_repeat (
         .CLK100MHZ (CLK100MHZ),
         .rst       (rst),
         .raw       (raw_s[g]),
         .tick      (tick_r),
         .held      (held[g]),
         .press     (press[g]),
         .cmd       (cmd[g])
      );
   end

   assign tick = tick_r;

endmodule

// File: doc/input_frontend.md
Name: input_frontend

Overview:
- Parametrised successor to the per-key input path in the top level, clocked directly on CLK100MHZ.
- Generates the game tick, synchronises and debounces N push-buttons, and decodes PS/2 make/break events into N held levels via a runtime key map.
- Produces per-channel one-shot and auto-repeat (DAS/ARR) command pulses.
- Sits between ps2_keyboard/board buttons and game_control; replaces the ad-hoc latch/OR logic and the fixed 60 Hz divider.

Parameters:
- N_KEYS, 5, number of input channels (left, right, down, rotate, drop by convention).
- TICK_DIV, 1666667, CLK100MHZ cycles per game tick (100 MHz / 60 Hz).
- DB_CYCLES, 1000000, consecutive stable cycles required before a debounced button changes (10 ms).
- DAS_TICKS, 10, ticks from press to the first auto-repeat.
- ARR_TICKS, 3, ticks between subsequent auto-repeats; must be >= 1.
- REPEAT_MASK, 5'b00111, per-channel auto-repeat enable; bit i = 0 means one-shot only.

Ports:
- CLK100MHZ  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- kb_valid  in  1  one-cycle strobe: new scan-code event.
- kb_code  in  8  scan code of the event.
- kb_make  in  1  1 = make, 0 = break.
- key_map  in  8*N_KEYS  scan code for channel i at bits [8i+7:8i].
- btn_raw  in  N_KEYS  asynchronous active-high buttons.
- tick  out  1  one-cycle game-tick pulse.
- held  out  N_KEYS  registered combined held level.
- press  out  N_KEYS  one-cycle pulse on rising edge of held.
- cmd  out  N_KEYS  one-cycle command pulse (press OR auto-repeat).

Behaviour:
Reset:
- Every output and all internal registers (counters, sync flops, debounced levels, kb latches) clear to 0 on the first rising edge with rst = 1.
- rst asserted mid-operation aborts any pending DAS/ARR count.
- After reset a physically held key is forgotten until its next make code arrives.

Tick:
- Counter runs 0..TICK_DIV-1 and wraps.
- tick is registered high for exactly the one cycle following counter == TICK_DIV-1.
- First tick comes TICK_DIV cycles after reset release.

Buttons:
- Two-flop synchroniser per bit.
- Per-channel debounce counter (width $clog2(DB_CYCLES+1)): counts while the synchronised value differs from the debounced value, and resets to 0 whenever they are equal.
- When the count reaches DB_CYCLES, the debounced value flips and the counter clears.
- A glitch shorter than DB_CYCLES never propagates.

Keyboard:
- On kb_valid, every channel i with key_map[i] == kb_code sets kb_held[i] <= kb_make.
- Multiple channels mapping to the same code all update.
- Events with no matching code, or with kb_valid low, change nothing.

Combine:
- raw[i] = kb_held[i] | btn_db[i].
- held <= raw, one cycle after raw.
- Releasing one source while the other is still active keeps held high.

Press:
- press[i] <= raw[i] & ~held[i], so press asserts in the same cycle held rises.

Repeat, per channel, states IDLE / DAS / ARR:
- IDLE -> DAS on press, loading rcnt = DAS_TICKS.
- In DAS/ARR, on each tick: if rcnt == 1, emit a repeat pulse, load rcnt = ARR_TICKS, and go to ARR; otherwise decrement rcnt.
- A press and a tick in the same cycle: the load wins, with no decrement.
- held falling in any state -> IDLE, rcnt = 0, no pulse, including when it coincides with a tick.
- REPEAT_MASK[i] = 0: channel stays in IDLE.

Output:
- cmd[i] = registered (press pulse | repeat pulse).
- Coincident press and repeat produce a single one-cycle pulse.
- Repeat pulses are tick-aligned: cmd is asserted the cycle after tick.

Widths:
- Tick counter uses $clog2(TICK_DIV) bits.
- rcnt uses $clog2(max(DAS_TICKS, ARR_TICKS)+1) bits.

Decomposition:
- Package input_pkg holds:
  - repeat-state enum rpt_state_t {IDLE, DAS, ARR};
  - scan-code constants LEFT/RIGHT/DOWN/UP arrow and SPACE;
  - default key map localparam;
  - channel index constants (KEY_LEFT = 0, …).
- One sub-module, key_repeat: a single channel's press detect plus DAS/ARR FSM, instantiated N_KEYS times in a generate loop.
- Tick generator, synchroniser, debounce and kb latch stay inline.

Test Plan:
Bench parameters: TICK_DIV=10, DB_CYCLES=4, DAS_TICKS=3, ARR_TICKS=2, N_KEYS=5, default map.
- Reset release, idle 35 cycles -> tick pulses at cycles 10, 20, 30 only; held/press/cmd stay 0.
- kb_valid with code 0x6B make -> held[0] rises with one press[0] and one cmd[0] pulse. Hold -> cmd[0] repeats after the 3rd tick following press, then every 2nd tick. Break code -> held[0] = 0, no further cmd.
- btn_raw[2] glitch of 3 cycles -> no held change. Held high for 10 cycles -> held[2] rises 4 cycles after the synchroniser output changes.
- Hold channel 4 (REPEAT_MASK bit 0) for 100 cycles -> exactly one cmd[4] pulse.
- Keyboard make on channel 1 plus button 1 held, then keyboard break -> held[1] stays 1, press[1] pulses only once.
- rst asserted for 1 cycle during the DAS count on channel 0 -> all outputs 0. No cmd until a new make event arrives, which then gives a fresh press and full DAS delay.
